// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage with IF/ID pipeline register.
// Owns the fetch PC, talks req/ack to instruction memory and honours stall/flush/redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        instr_valid_o
);

  // Memory handshake: imem_req_o/imem_addr_o stay stable from assertion until the
  // cycle imem_ack_i=1; ack may coincide with the first req cycle; ack without req is ignored.
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_e;

  state_e      state_q;
  logic        req_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] buf_q;
  logic [31:0] buf_pc_q;
  logic [31:0] pend_pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;

  logic [31:0] redir_tgt;
  logic [31:0] pc_inc;
  logic        ack;
  logic        load_mem;
  logic        load_buf;

  assign redir_tgt = {redirect_pc_i[31:2], 2'b00};
  assign pc_inc    = fetch_pc_q + 32'd4;
  assign ack       = imem_ack_i & req_q;
  assign load_mem  = (state_q == FETCH) && ack && !redirect_i && !stall_i;
  // A flush never consumes the buffered word; it stays parked until a clean cycle.
  assign load_buf  = (state_q == HOLD) && !redirect_i && !stall_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      buf_q      <= 32'h0;
      buf_pc_q   <= 32'h0;
      pend_pc_q  <= 32'h0;
      instr_q    <= 32'h0;
      pc_q       <= 32'h0;
      pc_plus4_q <= 32'd4;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (ack) begin
            if (redirect_i) begin
              fetch_pc_q <= redir_tgt;
            end else begin
              fetch_pc_q <= pc_inc;
              if (stall_i) begin
                buf_q    <= imem_rdata_i;
                buf_pc_q <= fetch_pc_q;
                state_q  <= HOLD;
                req_q    <= 1'b0;
              end
            end
          end else if (redirect_i) begin
            pend_pc_q <= redir_tgt;
            state_q   <= DRAIN;
          end
        end
        HOLD: begin
          if (redirect_i) begin
            fetch_pc_q <= redir_tgt;
            state_q    <= FETCH;
            req_q      <= 1'b1;
          end else if (load_buf) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        DRAIN: begin
          // The outstanding word is thrown away; the most recent redirect target wins.
          if (ack) begin
            fetch_pc_q <= redirect_i ? redir_tgt : pend_pc_q;
            state_q    <= FETCH;
          end else if (redirect_i) begin
            pend_pc_q <= redir_tgt;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase

      if (flush_i) begin
        instr_q <= 32'h0;
        valid_q <= 1'b0;
      end else if (!stall_i) begin
        if (load_mem) begin
          instr_q    <= imem_rdata_i;
          pc_q       <= fetch_pc_q;
          pc_plus4_q <= pc_inc;
          valid_q    <= 1'b1;
        end else if (load_buf) begin
          instr_q    <= buf_q;
          pc_q       <= buf_pc_q;
          pc_plus4_q <= buf_pc_q + 32'd4;
          valid_q    <= 1'b1;
        end else begin
          instr_q <= 32'h0;
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = fetch_pc_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4_q;
  assign instr_valid_o = valid_q;

endmodule
